write_back: RTL and testbench

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back.sv | 134 +++++++++++++
 tb/tb_write_back.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// write_back: MEM/WB pipeline stage register and register-file write port.
//
// Captures one instruction from the MEM stage per clock and presents it to
// the register file in the following cycle. A stalled instruction retires
// exactly once, however long the stall lasts. Retired instructions are
// counted in a free-running 32-bit counter that wraps to zero.
//
// Optional feature (compile-time macro WB_BYPASS_EN): when defined, the
// bypass_rs_hit / bypass_rt_hit ports and their address compares are built.
// When undefined, those ports and the compare logic are absent.
//
// Ports:
//   clk             in   clock; all state updates on the rising edge
//   reset           in   synchronous active-high reset
//   stall           in   hold the stage register
//   flush           in   load a bubble (priority over stall)
//   mem_valid       in   MEM stage presents a real instruction
//   wb_RegWrite_in  in   instruction writes the register file
//   wb_MemtoReg_in  in   1 = write memory data, 0 = write ALU result
//   mem_read_data   in   [B-1:0] data-memory read value
//   alu_result      in   [B-1:0] ALU result
//   write_reg       in   [W-1:0] destination register address
//   id_rs, id_rt    in   [W-1:0] decode-stage source addresses
//   RegWrite        out  register-file write enable
//   address_write   out  [W-1:0] register-file write address
//   data_write      out  [B-1:0] register-file write data
//   wb_valid        out  an instruction retires this cycle
//   retired_count   out  [31:0] retired-instruction counter
//   bypass_rs_hit   out  (WB_BYPASS_EN) write port matches id_rs
//   bypass_rt_hit   out  (WB_BYPASS_EN) write port matches id_rt
//
// RegWrite, address_write, data_write, wb_valid and the bypass hits are
// combinational decodes of the stage register; they carry no logic from the
// module inputs apart from the id_rs/id_rt compares.

module write_back #(
   parameter int unsigned B = 32,
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         mem_valid,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic [B-1:0] mem_read_data,
   input  logic [B-1:0] alu_result,
   input  logic [W-1:0] write_reg,
   input  logic [W-1:0] id_rs,
   input  logic [W-1:0] id_rt,
   output logic         RegWrite,
   output logic [W-1:0] address_write,
   output logic [B-1:0] data_write,
   output logic         wb_valid,
   output logic [31:0]  retired_count
`ifdef WB_BYPASS_EN
   ,
   output logic         bypass_rs_hit,
   output logic         bypass_rt_hit
`endif
);

   localparam int unsigned CNT_W = 32;

   // Stage register contents
   logic         valid_q;
   logic         regwrite_q;
   logic         memtoreg_q;
   logic         committed_q;
   logic [B-1:0] mem_data_q;
   logic [B-1:0] alu_q;
   logic [W-1:0] addr_q;

   // Stage register: reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         committed_q <= 1'b0;
         mem_data_q  <= '0;
         alu_q       <= '0;
         addr_q      <= '0;
      end else if (flush) begin
         // Bubble: data fields are don't-care once valid is low
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         committed_q <= 1'b0;
      end else if (stall) begin
         // A held instruction has retired after its first cycle in the stage
         if (valid_q) begin
            committed_q <= 1'b1;
         end
      end else begin
         valid_q     <= mem_valid;
         regwrite_q  <= wb_RegWrite_in;
         memtoreg_q  <= wb_MemtoReg_in;
         committed_q <= 1'b0;
         mem_data_q  <= mem_read_data;
         alu_q       <= alu_result;
         addr_q      <= write_reg;
      end
   end

   // Retirement and write-port decode
   always_comb begin
      wb_valid      = valid_q & ~committed_q;
      RegWrite      = wb_valid & regwrite_q & (addr_q != W'(0));
      address_write = addr_q;
      data_write    = memtoreg_q ? mem_data_q : alu_q;
   end

   // Retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_count <= '0;
      end else if (wb_valid) begin
         retired_count <= retired_count + CNT_W'(1);
      end
   end

`ifdef WB_BYPASS_EN
   // Decode-stage bypass compares against the live write port
   always_comb begin
      bypass_rs_hit = RegWrite & (addr_q == id_rs);
      bypass_rt_hit = RegWrite & (addr_q == id_rt);
   end
`else
   logic unused_id_c;
   assign unused_id_c = ^{id_rs, id_rt};
`endif

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed scoreboard bench for write_back.
// Each step drives one set of inputs, pushes the outputs expected after the
// next rising edge, then pops and compares them #1 after that edge.

module tb_write_back;

   localparam int unsigned B = 32;
   localparam int unsigned W = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall;
   logic         flush;
   logic         mem_valid;
   logic         wb_RegWrite_in;
   logic         wb_MemtoReg_in;
   logic [B-1:0] mem_read_data;
   logic [B-1:0] alu_result;
   logic [W-1:0] write_reg;
   logic [W-1:0] id_rs;
   logic [W-1:0] id_rt;
   logic         RegWrite;
   logic [W-1:0] address_write;
   logic [B-1:0] data_write;
   logic         wb_valid;
   logic [31:0]  retired_count;
`ifdef WB_BYPASS_EN
   logic         bypass_rs_hit;
   logic         bypass_rt_hit;
`endif

   write_back #(.B(B), .W(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .wb_RegWrite_in (wb_RegWrite_in),
      .wb_MemtoReg_in (wb_MemtoReg_in),
      .mem_read_data  (mem_read_data),
      .alu_result     (alu_result),
      .write_reg      (write_reg),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .RegWrite       (RegWrite),
      .address_write  (address_write),
      .data_write     (data_write),
      .wb_valid       (wb_valid),
      .retired_count  (retired_count)
`ifdef WB_BYPASS_EN
      ,
      .bypass_rs_hit  (bypass_rs_hit),
      .bypass_rt_hit  (bypass_rt_hit)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        wv;
      logic [31:0] cnt;
      bit          chk_dp;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue expectations, compare after the edge
   task automatic step(input string tag,
                       input logic rst, input logic stl, input logic fls,
                       input logic mv, input logic rwi, input logic mtr,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] wr,
                       input logic e_rw, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic e_wv,
                       input logic [31:0] e_cnt, input bit e_chk_dp);
      exp_t e;
      exp_t got;
      reset = rst; stall = stl; flush = fls; mem_valid = mv;
      wb_RegWrite_in = rwi; wb_MemtoReg_in = mtr;
      mem_read_data = mem; alu_result = alu; write_reg = wr;
      e.rw = e_rw; e.addr = e_addr; e.data = e_data; e.wv = e_wv;
      e.cnt = e_cnt; e.chk_dp = e_chk_dp;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
      end else begin
         got = exp_q.pop_front();
         check({tag, ".RegWrite"},      32'(RegWrite),      32'(got.rw));
         check({tag, ".wb_valid"},      32'(wb_valid),      32'(got.wv));
         check({tag, ".retired_count"}, retired_count,      got.cnt);
         if (got.chk_dp) begin
            check({tag, ".address_write"}, 32'(address_write), 32'(got.addr));
            check({tag, ".data_write"},    data_write,         got.data);
         end
      end
   endtask

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
      wb_RegWrite_in = 1'b0; wb_MemtoReg_in = 1'b0;
      mem_read_data = '0; alu_result = '0; write_reg = '0;
      id_rs = '0; id_rt = '0;
      @(posedge clk);
      #1;

      // Reset state, held over two edges
      step("reset0", 1,0,0, 1,1,0, 32'h0, 32'h1111, 5'd2,  0,5'd0,32'h0,0,32'd0,1);
      step("reset1", 1,1,1, 1,1,1, 32'h2, 32'h2222, 5'd3,  0,5'd0,32'h0,0,32'd0,1);

      // ALU write to r8
      step("alu_wr", 0,0,0, 1,1,0, 32'hCAFE_0000, 32'h0000_1234, 5'd8,
           1,5'd8,32'h0000_1234,1,32'd0,1);
      // Load to $zero: retires but does not write
      step("ld_zero", 0,0,0, 1,1,1, 32'hDEAD_BEEF, 32'h5555_5555, 5'd0,
           0,5'd0,32'hDEAD_BEEF,1,32'd1,1);
      // Instruction to r3 then stall three cycles
      step("st_load", 0,0,0, 1,1,0, 32'h0, 32'hAAAA_0003, 5'd3,
           1,5'd3,32'hAAAA_0003,1,32'd2,1);
      step("stall1", 0,1,0, 1,1,1, 32'hFFFF, 32'hFFFF, 5'd9,
           0,5'd3,32'hAAAA_0003,0,32'd3,1);
      step("stall2", 0,1,0, 1,1,1, 32'hFFFF, 32'hFFFF, 5'd9,
           0,5'd3,32'hAAAA_0003,0,32'd3,1);
      step("stall3", 0,1,0, 1,1,1, 32'hFFFF, 32'hFFFF, 5'd9,
           0,5'd3,32'hAAAA_0003,0,32'd3,1);
      // Flush wins over stall
      step("flush_stall", 0,1,1, 1,1,0, 32'h0, 32'h7777, 5'd7,
           0,5'd0,32'h0,0,32'd3,0);
      // Bubble from mem_valid=0
      step("bubble", 0,0,0, 0,1,0, 32'h0, 32'h8888, 5'd8,
           0,5'd8,32'h8888,0,32'd3,1);

      // Counter wrap: preload at all-ones while the stage holds a bubble
      dut.retired_count = 32'hFFFF_FFFF;
      step("wrap_ld", 0,0,0, 1,1,0, 32'h0, 32'h0000_0077, 5'd7,
           1,5'd7,32'h0000_0077,1,32'hFFFF_FFFF,1);
      step("wrap", 0,0,0, 0,0,0, 32'h0, 32'h0, 5'd0,
           0,5'd0,32'h0,0,32'd0,1);

      // Reset with a valid instruction staged
      step("pre_rst", 0,0,0, 1,1,0, 32'h0, 32'h0000_0044, 5'd4,
           1,5'd4,32'h0000_0044,1,32'd0,1);
      step("rst_staged", 1,1,0, 1,1,0, 32'h0, 32'h0000_0099, 5'd9,
           0,5'd0,32'h0,0,32'd0,1);
      step("post_rst", 0,0,0, 0,0,0, 32'h0, 32'h0, 5'd0,
           0,5'd0,32'h0,0,32'd0,1);

`ifdef WB_BYPASS_EN
      id_rs = 5'd5; id_rt = 5'd6;
      step("byp_r5", 0,0,0, 1,1,0, 32'h0, 32'h0000_0055, 5'd5,
           1,5'd5,32'h0000_0055,1,32'd0,1);
      check("byp_rs_hit", 32'(bypass_rs_hit), 32'd1);
      check("byp_rt_hit", 32'(bypass_rt_hit), 32'd0);
      id_rs = 5'd0;
      step("byp_r0", 0,0,0, 1,1,0, 32'h0, 32'h0000_0066, 5'd0,
           0,5'd0,32'h0000_0066,1,32'd1,1);
      check("byp_rs_zero", 32'(bypass_rs_hit), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
